muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in operand width, executing all eight `muldiv_type` operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) with a start/valid handshake. It sits beside the ALU in the execute stage. The HDU stalls the pipeline while `busy_o` is high. Radix-2 shift-add multiply and restoring divide take one bit per cycle. RISC-V divide-by-zero and overflow corner cases are resolved on a 2-cycle fast path.

## Interface
- `DATA_W`, default `` `data_size `` (32): operand/result width, even, ≥ 8.
- `CNT_W`, default `log2(DATA_W)`: iteration counter width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  launch operation; sampled only in IDLE or DONE.
- `flush_i`  in  1  abort the current operation (branch mispredict or exception).
- `op_i`  in  3  `muldiv_type`, captured with `start_i`.
- `rs1_i`  in  DATA_W  dividend / multiplicand, captured with `start_i`.
- `rs2_i`  in  DATA_W  divisor / multiplier, captured with `start_i`.
- `busy_o`  out  1  high in PREP and CALC.
- `valid_o`  out  1  one-cycle pulse; `result_o` is valid.
- `result_o`  out  DATA_W  result, held until the next DONE.

## Operation
- FSM states: IDLE, PREP, CALC, DONE (`muldiv_state`).
- **IDLE / DONE**
  - `start_i` with `!flush_i` → PREP. Captures `op_i`, `rs1_i`, `rs2_i`.
  - Otherwise → IDLE.
- **PREP**
  - Compute operand signs:
    - MULH/DIV/REM: both operands signed.
    - MULHSU: rs1 signed, rs2 unsigned.
    - Others: unsigned.
  - Load absolute values. Load counter = DATA_W−1.
  - Fast path → DONE, with no CALC:
    - Divide-by-zero (rs2 == 0):
      - DIV/DIVU: all-ones.
      - REM/REMU: rs1.
    - Signed overflow (DIV/REM with rs1 = 100…0 and rs2 = all-ones):
      - DIV: rs1.
      - REM: 0.
  - Otherwise → CALC.
- **CALC**
  - One iteration per cycle:
    - Multiply: 2·DATA_W product register, conditional add and shift right.
    - Divide: partial remainder, shift left, trial subtract, quotient bit.
  - Counter decrements. At counter == 0 → DONE.
- **DONE entry**
  - Apply sign correction:
    - Product: negate if the operand signs differ.
    - Quotient: negate if the operand signs differ.
    - Remainder: takes the dividend's sign.
  - Select the result:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half.
  - Register into `result_o`. `valid_o` = 1 for exactly the DONE cycle.
- **Flush**
  - `flush_i` in any state → IDLE on the next edge.
  - No `valid_o`, `result_o` unchanged.
  - Flush beats a simultaneous `start_i`.
- `start_i` in PREP/CALC is ignored. There is no queueing.
- Reset (asynchronous, any state):
  - State IDLE.
  - `busy_o` = 0, `valid_o` = 0, `result_o` = 0.
  - Internal registers cleared.
  - Mid-operation results are lost.

## Timing
- `start_i` sampled at edge 0:
  - PREP during cycle 1.
  - CALC during cycles 2…DATA_W+1.
  - DONE (`valid_o`) during cycle DATA_W+2.
- Normal latency: DATA_W+2 cycles (34 at DATA_W = 32).
- Fast-path latency: 2 cycles (DONE in cycle 2).
- Back-to-back: `start_i` during the DONE cycle enters PREP next cycle, giving a throughput of DATA_W+2 cycles.
- `busy_o` rises in the cycle after the start edge and falls in the DONE cycle. The HDU adds its own 1-cycle accept.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Constants package additions:
  - `typedef enum logic[1:0] {MD_IDLE, MD_PREP, MD_CALC, MD_DONE} muldiv_state`.
  - `` `define muldiv_latency (`data_size+2) `` for the HDU.
  - `muldiv_type` is reused unchanged.
- Sub-module `muldiv_step`: combinational single-iteration datapath (add/shift and subtract/compare), parametrised by DATA_W. Instantiated once.
- `muldiv_unit` holds the FSM, counter, sign logic and output registers.

## Test plan
- MUL rs1 = 7, rs2 = 0xFFFFFFFD → `result_o` = 0xFFFFFFEB; `valid_o` in cycle 34 only; `busy_o` high in cycles 1–33.
- rs1 = rs2 = 0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
- rs1 = 0xFFFFFFF9 (−7), rs2 = 2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU with rs1 = 7, rs2 = 2 → 3; back-to-back via start during DONE.
- Fast path, `valid_o` in cycle 2:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Flush:
  - `flush_i` in cycle 10 of a MUL → IDLE next cycle, no `valid_o`, `result_o` keeps its old value.
  - Simultaneous `start_i` + `flush_i` in IDLE → stays IDLE.
- `rst_n` low in cycle 15 of a DIV → `busy_o`/`valid_o`/`result_o` = 0 immediately (before the next edge); a new op after release completes correctly.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit.
// Holds the operation encoding, FSM states and the HDU latency macro.
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef MULDIV_LATENCY
`define MULDIV_LATENCY (`DATA_SIZE+2)
`endif

package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_type;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_PREP,
    MD_CALC,
    MD_DONE
  } muldiv_state;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide step.
// Ports: div_i selects divide, acc_i/acc_o 2W accumulator, opnd_i operand.
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic                  div_i,
  input  logic [2*DATA_W-1:0]   acc_i,
  input  logic [DATA_W-1:0]     opnd_i,
  output logic [2*DATA_W-1:0]   acc_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   part;
  logic [DATA_W-1:0] diff;

  always_comb begin
    sum  = {1'b0, acc_i[2*DATA_W-1:DATA_W]}
         + (acc_i[0] ? {1'b0, opnd_i} : '0);
    // remainder shifted left with next dividend bit
    part = {acc_i[2*DATA_W-1:DATA_W], acc_i[DATA_W-1]};
    // result fits W bits whenever part >= divisor
    diff = part[DATA_W-1:0] - opnd_i;
    if (div_i) begin
      if (part >= {1'b0, opnd_i}) begin
        acc_o = {diff, acc_i[DATA_W-2:0], 1'b1};
      end else begin
        acc_o = {part[DATA_W-1:0], acc_i[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum, acc_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/valid handshake.
// Ports: start/flush/op/rs1/rs2 in; busy, valid pulse, result out.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = `DATA_SIZE,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              flush_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int W2 = 2 * DATA_W;

  muldiv_state       state_q, state_d;
  muldiv_type        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [W2-1:0]     acc_q, acc_d, step_acc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              negm_q, negm_d;
  logic              negr_q, negr_d;

  logic              div_op, sgn_a, sgn_b;
  logic              neg_a, neg_b;
  logic              zero_b, ovf, fast;
  logic [DATA_W-1:0] abs_a, abs_b, fast_res;
  logic [W2-1:0]     prod;
  logic [DATA_W-1:0] quo, rem, calc_res;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .div_i  (div_op),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc)
  );

  assign div_op = op_q[2];
  assign sgn_a  = op_q inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  assign sgn_b  = op_q inside {MD_MULH, MD_DIV, MD_REM};
  assign neg_a  = sgn_a & a_q[DATA_W-1];
  assign neg_b  = sgn_b & b_q[DATA_W-1];
  assign abs_a  = neg_a ? -a_q : a_q;
  assign abs_b  = neg_b ? -b_q : b_q;

  assign zero_b = (b_q == '0);
  assign ovf    = (op_q inside {MD_DIV, MD_REM})
                & (a_q == {1'b1, {(DATA_W-1){1'b0}}})
                & (b_q == '1);
  assign fast   = div_op & (zero_b | ovf);

  // op_q[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    fast_res = a_q;
    unique case (1'b1)
      zero_b & ~op_q[1]: fast_res = '1;
      zero_b &  op_q[1]: fast_res = a_q;
      ~zero_b & op_q[1]: fast_res = '0;
      default:           fast_res = a_q;
    endcase
  end

  // sign correction applied to the final iteration's output
  assign prod = negm_q ? -step_acc : step_acc;
  assign quo  = negm_q ? -step_acc[DATA_W-1:0]
                       : step_acc[DATA_W-1:0];
  assign rem  = negr_q ? -step_acc[W2-1:DATA_W]
                       : step_acc[W2-1:DATA_W];

  always_comb begin
    calc_res = rem;
    unique case (op_q)
      MD_MUL:                       calc_res = prod[DATA_W-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: calc_res = prod[W2-1:DATA_W];
      MD_DIV, MD_DIVU:              calc_res = quo;
      MD_REM, MD_REMU:              calc_res = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    negm_d  = negm_q;
    negr_d  = negr_q;
    res_d   = res_q;
    unique case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (start_i) begin
          state_d = MD_PREP;
          op_d    = muldiv_type'(op_i);
          a_d     = rs1_i;
          b_d     = rs2_i;
        end
      end
      MD_PREP: begin
        // mul: multiplier in low half; div: dividend in low half
        acc_d  = {{DATA_W{1'b0}}, div_op ? abs_a : abs_b};
        opnd_d = div_op ? abs_b : abs_a;
        cnt_d  = CNT_W'(DATA_W - 1);
        negm_d = neg_a ^ neg_b;
        negr_d = neg_a;
        if (fast) begin
          state_d = MD_DONE;
          res_d   = fast_res;
        end else begin
          state_d = MD_CALC;
        end
      end
      MD_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = MD_DONE;
          res_d   = calc_res;
        end
      end
    endcase
    if (flush_i) begin
      state_d = MD_IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      op_q    <= MD_MUL;
      a_q     <= '0;
      b_q     <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      negm_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      negm_q  <= negm_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
    end
  end

  assign busy_o   = (state_q == MD_PREP) | (state_q == MD_CALC);
  assign valid_o  = (state_q == MD_DONE);
  assign result_o = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: reference model plus directed cases.
// Random start/flush traffic is compared with the model every cycle.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int checks   = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M semantics computed with 64-bit arithmetic
  function automatic logic [31:0] ref_res(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, st;
    logic [63:0]        ua, ub, ut;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin ut = ua * ub; return ut[31:0]; end
      3'd1: begin st = sa * sb; return st[63:32]; end
      3'd2: begin st = sa * $signed(ub); return st[63:32]; end
      3'd3: begin ut = ua * ub; return ut[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        st = sa / sb; return st[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        st = sa % sb; return st[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 ||
        (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)))
      return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // model: cycles left until the DONE cycle of the accepted op
  bit          m_act;
  int          m_left;
  logic [31:0] m_pend;
  logic [31:0] m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  = 1'b0;
      m_left = 0;
      m_res  = 32'd0;
    end else if (flush_i) begin
      m_act = 1'b0;
    end else if (m_act && m_left > 0) begin
      m_left--;
      if (m_left == 0) m_res = m_pend;
    end else if (start_i) begin
      m_act  = 1'b1;
      m_left = ref_lat(op_i, rs1_i, rs2_i) - 1;
      m_pend = ref_res(op_i, rs1_i, rs2_i);
    end else begin
      m_act = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("valid", {31'd0, valid_o},
            {31'd0, m_act && m_left == 0});
      check("busy", {31'd0, busy_o},
            {31'd0, m_act && m_left > 0});
      check("result", result_o, m_res);
    end
  end

  task automatic launch(input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!valid_o && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!valid_o) begin
      failures++;
      $display("FAIL timeout: no valid_o after %0d cycles", cyc);
    end
  endtask

  task automatic run_op(input string nm, input bit b2b,
                        input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat);
    int cyc;
    if (!b2b) @(negedge clk);
    launch(op, a, b);
    wait_valid(cyc);
    check({nm, "_res"}, result_o, exp);
    check({nm, "_lat"}, cyc, lat);
  endtask

  initial begin
    int cyc;
    rst_n   = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    op_i    = 3'd0;
    rs1_i   = 32'd0;
    rs2_i   = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    rst_n = 1'b1;

    run_op("mul", 0, 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("mulhu", 0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 34);
    run_op("mulh", 0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'h00000000, 34);
    run_op("mulhsu", 0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFF, 34);
    run_op("div", 0, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run_op("rem", 0, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run_op("divu_b2b", 1, 3'd5, 32'd7, 32'd2, 32'd3, 34);
    run_op("div0", 0, 3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 2);
    run_op("remu0", 0, 3'd7, 32'd5, 32'd0, 32'd5, 2);
    run_op("div_ovf", 0, 3'd4, 32'h80000000, 32'hFFFFFFFF,
           32'h80000000, 2);
    run_op("rem_ovf", 0, 3'd6, 32'h80000000, 32'hFFFFFFFF,
           32'd0, 2);

    // flush in cycle 10 of a MUL
    @(negedge clk);
    launch(3'd0, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_busy", {31'd0, busy_o}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_hold", result_o, 32'd0);

    // start together with flush in IDLE
    start_i = 1'b1;
    flush_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    check("sflush_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    check("sflush_valid", {31'd0, valid_o}, 32'd0);

    // asynchronous reset mid-divide
    run_op("pre_rst", 0, 3'd5, 32'd100, 32'd7, 32'd14, 34);
    @(negedge clk);
    launch(3'd4, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy_o}, 32'd0);
    check("arst_valid", {31'd0, valid_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_op("post_rst", 0, 3'd5, 32'd7, 32'd2, 32'd3, 34);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start_i = ($urandom % 6) == 0;
      flush_i = ($urandom % 80) == 0;
      op_i    = 3'($urandom % 8);
      rs1_i   = pick();
      rs2_i   = pick();
    end
    @(negedge clk);
    start_i = 1'b0;
    flush_i = 1'b0;
    repeat (50) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
